// File: rtl/sequenciador_decodificador.sv
// Session controller for the 7-bit symbol decoder: buffers symbols in a small FIFO,
// clears the decoder, strobes one symbol at a time and classifies the decoder state.
module sequenciador_decodificador #(
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 16,
  parameter int MAX_SYMS = 12
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [6:0] in_data,
  output logic       in_ready,
  output logic [6:0] dec_entrada,
  output logic       dec_controle,
  output logic       dec_reset,
  input  logic [3:0] dec_saida,
  output logic       busy,
  output logic       done,
  output logic [1:0] result,
  output logic [3:0] sym_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] RES_TIMEOUT = 2'b00;
  localparam logic [1:0] RES_A       = 2'b01;
  localparam logic [1:0] RES_B       = 2'b10;
  localparam logic [1:0] RES_ERROR   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t        state;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] timer;
  logic          full, empty, push, pop;
  logic [3:0]    sym_count_next;
  logic          check_end;
  logic [1:0]    check_code;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && (state != S_CLEAR);
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_ISSUE) && !empty;

  assign sym_count_next = sym_count + 4'd1;

  // Accept/error codes win over the length limit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    check_end  = 1'b1;
    check_code = RES_ERROR;
    case (dec_saida)
      4'b1000: check_code = RES_ERROR;
      4'b1001: check_code = RES_A;
      4'b1010: check_code = RES_B;
      default: check_end  = (sym_count_next == 4'(MAX_SYMS));
    endcase
  end

  // NOTE: storage has no reset; count alone decides which entries hold valid data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (state == S_CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state        <= S_IDLE;
      dec_reset    <= 1'b1;
      dec_controle <= 1'b0;
      dec_entrada  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= RES_TIMEOUT;
      sym_count    <= '0;
      timer        <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
      dec_controle <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE: begin
          dec_reset <= 1'b0;
          if (start) begin
            state     <= S_CLEAR;
            dec_reset <= 1'b1;
            busy      <= 1'b1;
            result    <= RES_TIMEOUT;
            sym_count <= '0;
            timer     <= '0;
          end
        end
        S_CLEAR: begin
          state     <= S_ISSUE;
          dec_reset <= 1'b0;
        end
        S_ISSUE: begin
          if (!empty) begin
            dec_entrada  <= mem[rd_ptr];
            dec_controle <= 1'b1;
            timer        <= '0;
            state        <= S_WAIT;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state  <= S_DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            result <= RES_TIMEOUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT: state <= S_CHECK;
        S_CHECK: begin
          sym_count <= sym_count_next;
          if (check_end) begin
            state  <= S_DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            result <= check_code;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequenciador_decodificador.sv
// Directed bench for sequenciador_decodificador; a table-driven decoder model answers each strobe.
module tb_sequenciador_decodificador;

  localparam int DEPTH    = 4;
  localparam int TIMEOUT  = 16;
  localparam int MAX_SYMS = 12;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] in_data = '0;
  logic       in_ready;
  logic [6:0] dec_entrada;
  logic       dec_controle;
  logic       dec_reset;
  logic [3:0] dec_saida = '0;
  logic       busy;
  logic       done;
  logic [1:0] result;
  logic [3:0] sym_count;

  always #5 clk = ~clk;

  sequenciador_decodificador #(
    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_SYMS(MAX_SYMS)
  ) dut (
    .clk(clk), .Reset(Reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dec_entrada(dec_entrada), .dec_controle(dec_controle), .dec_reset(dec_reset),
    .dec_saida(dec_saida), .busy(busy), .done(done), .result(result),
    .sym_count(sym_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Decoder model: the n-th strobe of a test loads resp_tab[n]; Reset clears it.
  logic [3:0] resp_tab [32];
  int         resp_base = 0;
  int         strobes = 0;
  int         viol = 0;
  int         cyc = 0;
  int         last_strobe = -10;
  logic [6:0] seen_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dec_reset) dec_saida <= '0;
    else if (dec_controle) dec_saida <= resp_tab[5'(strobes - resp_base)];
    if (dec_controle) begin
      strobes     <= strobes + 1;
      last_strobe <= cyc;
      seen_q.push_back(dec_entrada);
      if (dec_reset || (cyc - last_strobe) < 3) viol <= viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_resp(input logic [3:0] r0, input logic [3:0] r1);
    for (int i = 0; i < 32; i++) resp_tab[i] = 4'b0000;
    resp_tab[0] = r0;
    resp_tab[1] = r1;
    resp_base   = strobes;
  endtask

  task automatic start_session();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_sym(input logic [6:0] d);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_stuck", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (!done && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  // Offers six symbols in IDLE; only the first DEPTH may be accepted.
  task automatic fill_idle(input string tag);
    logic [5:0] rdy;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy[i]   = in_ready;
      in_valid = 1'b1;
      in_data  = 7'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check(tag, rdy, 6'b001111);
  endtask

  logic [6:0] t4_syms [6] = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};
  int cycles;
  int sbase;
  int seen_base;

  initial begin
    for (int i = 0; i < 32; i++) resp_tab[i] = 4'b0000;

    // Reset state
    #2 Reset = 1'b0;
    #1;
    check("rst_dec_reset", dec_reset, 1);
    check("rst_dec_controle", dec_controle, 0);
    check("rst_dec_entrada", dec_entrada, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_sym_count", sym_count, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("idle_dec_reset", dec_reset, 0);

    // 1: accept A after two symbols
    set_resp(4'b0001, 4'b1001);
    sbase = strobes;
    seen_base = seen_q.size();
    start_session();
    check("t1_busy", busy, 1);
    check("t1_clear_dec_reset", dec_reset, 1);
    check("t1_clear_in_ready", in_ready, 0);
    push_sym(7'b1100000);
    push_sym(7'b1001001);
    wait_done("t1", cycles);
    check("t1_result", result, 2'b01);
    check("t1_sym_count", sym_count, 2);
    check("t1_strobes", strobes - sbase, 2);
    check("t1_sym0", seen_q[seen_base], 7'b1100000);
    check("t1_sym1", seen_q[seen_base + 1], 7'b1001001);
    @(negedge clk);
    check("t1_done_pulse", done, 0);

    // 2: error code from decoder
    set_resp(4'b0001, 4'b1000);
    start_session();
    push_sym(7'b1100000);
    push_sym(7'b1111100);
    wait_done("t2", cycles);
    check("t2_result", result, 2'b11);
    check("t2_sym_count", sym_count, 2);

    // 3: timeout; ISSUE is entered on the edge after the CLEAR negedge, done
    // rises TIMEOUT edges later, so it is seen on negedge TIMEOUT+1.
    set_resp(4'b0000, 4'b0000);
    @(negedge clk);
    start_session();
    wait_done("t3", cycles);
    check("t3_latency", cycles, TIMEOUT + 1);
    check("t3_result", result, 2'b00);
    check("t3_sym_count", sym_count, 0);

    // 4: FIFO fills in IDLE, then order through a session with a stalled decoder
    @(negedge clk);
    fill_idle("t4_full_ready");
    set_resp(4'b0000, 4'b0000);
    sbase = strobes;
    seen_base = seen_q.size();
    start_session();
    for (int i = 0; i < 6; i++) push_sym(t4_syms[i]);
    wait_done("t4", cycles);
    check("t4_strobes", strobes - sbase, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t4_order%0d", i), seen_q[seen_base + i], t4_syms[i]);
    check("t4_result", result, 2'b00);
    check("t4_sym_count", sym_count, 6);

    // 5: reset dropped mid-WAIT
    set_resp(4'b0000, 4'b0000);
    start_session();
    push_sym(7'b0000001);
    push_sym(7'b0000010);
    push_sym(7'b0000011);
    cycles = 0;
    while (!dec_controle && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check("t5_reach_wait", dec_controle, 1);
    Reset = 1'b0;
    #1;
    check("t5_controle", dec_controle, 0);
    check("t5_dec_reset", dec_reset, 1);
    check("t5_busy", busy, 0);
    check("t5_sym_count", sym_count, 0);
    @(negedge clk);
    Reset = 1'b1;
    fill_idle("t5_fifo_empty");
    set_resp(4'b0001, 4'b1001);
    start_session();
    push_sym(7'b1100000);
    push_sym(7'b1001001);
    wait_done("t5_after", cycles);
    check("t5_after_result", result, 2'b01);
    check("t5_after_sym_count", sym_count, 2);

    // 6: length limit
    set_resp(4'b0000, 4'b0000);
    sbase = strobes;
    start_session();
    for (int i = 0; i < MAX_SYMS; i++) push_sym((i % 2 == 0) ? 7'b1100000 : 7'b1000100);
    wait_done("t6", cycles);
    check("t6_result", result, 2'b11);
    check("t6_sym_count", sym_count, MAX_SYMS);
    check("t6_strobes", strobes - sbase, MAX_SYMS);
    repeat (3) @(negedge clk);
    check("t6_result_held", result, 2'b11);

    check("strobe_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
